engine_cmd_tx: RTL and testbench

- Host-side command serializer that feeds the DSP engine's SPI command FIFO.
- Accepts one parallel command request (opcode, block, register, data), breaks it into a byte frame and drives command_out/command_out_ready.
- Paces bytes from the engine's fifo_count so the FIFO never overflows.
- Sits between the SPI/host bridge (or a local parameter sequencer) and the engine's command input.

---
 rtl/engine_cmd_tx.sv | 160 ++++++++++++++++
 tb/tb_engine_cmd_tx.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/engine_cmd_tx.sv
// Host-side command serializer: splits one parallel request into a byte frame for the
// engine's SPI command FIFO, paced by fifo_count. Define CMD_TX_CHECKSUM_EN to append an XOR checksum byte.
module engine_cmd_tx #(
  parameter int n_blocks          = 256,
  parameter int n_block_registers = 16,
  parameter int data_width        = 16,
  parameter int spi_fifo_length   = 32
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 req_valid,
  output logic                                 req_ready,
  input  logic [7:0]                           req_opcode,
  input  logic [$clog2(n_blocks)-1:0]          req_block,
  input  logic [$clog2(n_block_registers)-1:0] req_reg,
  input  logic [data_width-1:0]                req_data,
  input  logic [2:0]                           req_len,
  output logic [7:0]                           command_out,
  output logic                                 command_out_ready,
  input  logic [$clog2(spi_fifo_length):0]     fifo_count,
  input  logic                                 invalid_command,
  output logic                                 busy,
  output logic                                 error,
  output logic [15:0]                          frames_sent
);

  localparam int MAXLEN = 3 + data_width / 8;
  localparam int FW     = MAXLEN * 8;
  localparam int IW     = $clog2(MAXLEN + 1);
  localparam int FCW    = $clog2(spi_fifo_length) + 1;
  localparam logic [FCW-1:0] CREDIT_MAX = FCW'(spi_fifo_length - 2);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND
`ifdef CMD_TX_CHECKSUM_EN
    , ST_CKSUM
`endif
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [IW-1:0]   len_q, len_d;
  logic [FW-1:0]   frame_q, frame_d;
  logic [7:0]      out_q, out_d;
  logic            stb_q, stb_d;
  logic            err_q, err_d;
  logic [15:0]     cnt_q, cnt_d;
`ifdef CMD_TX_CHECKSUM_EN
  logic [7:0]      cks_q, cks_d;
`endif

  logic credit;
  assign credit = (fifo_count <= CREDIT_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      frame_q <= '0;
      out_q   <= '0;
      stb_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
`ifdef CMD_TX_CHECKSUM_EN
      cks_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      frame_q <= frame_d;
      out_q   <= out_d;
      stb_q   <= stb_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
`ifdef CMD_TX_CHECKSUM_EN
      cks_q   <= cks_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    frame_d = frame_q;
    out_d   = out_q;
    stb_d   = 1'b0;
    err_d   = err_q;
    cnt_d   = cnt_q;
`ifdef CMD_TX_CHECKSUM_EN
    cks_d   = cks_q;
`endif
    if (invalid_command) err_d = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (req_len == 3'd0) begin
            err_d = 1'b1;
          end else begin
            if (int'(req_len) > MAXLEN) begin
              err_d = 1'b1;
              len_d = IW'(MAXLEN);
            end else begin
              len_d = IW'(req_len);
            end
            idx_d   = '0;
            // Frame is latched MSB-first so each issue just takes the top byte and shifts.
            frame_d = {req_opcode, 8'(req_block), 8'(req_reg), req_data};
`ifdef CMD_TX_CHECKSUM_EN
            cks_d   = '0;
`endif
            state_d = ST_SEND;
          end
        end
      end
      ST_SEND: begin
        if (credit) begin
          out_d   = frame_q[FW-1 -: 8];
          frame_d = frame_q << 8;
          stb_d   = 1'b1;
          idx_d   = idx_q + IW'(1);
`ifdef CMD_TX_CHECKSUM_EN
          cks_d   = cks_q ^ frame_q[FW-1 -: 8];
`endif
          if (idx_q == len_q - IW'(1)) begin
`ifdef CMD_TX_CHECKSUM_EN
            state_d = ST_CKSUM;
`else
            state_d = ST_IDLE;
            cnt_d   = cnt_q + 16'd1;
`endif
          end
        end
      end
`ifdef CMD_TX_CHECKSUM_EN
      ST_CKSUM: begin
        if (credit) begin
          out_d   = cks_q;
          stb_d   = 1'b1;
          cnt_d   = cnt_q + 16'd1;
          state_d = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  assign req_ready         = (state_q == ST_IDLE);
  assign busy              = (state_q != ST_IDLE);
  assign command_out       = out_q;
  assign command_out_ready = stb_q;
  assign error             = err_q;
  assign frames_sent       = cnt_q;

endmodule

// File: tb/tb_engine_cmd_tx.sv
// Self-checking bench for engine_cmd_tx: randomized requests and FIFO back-pressure
// compared against a byte-list reference model of the frame format.
module tb_engine_cmd_tx;

  localparam int FL     = 32;
  localparam int DW     = 16;
  localparam int MAXLEN = 3 + DW / 8;
`ifdef CMD_TX_CHECKSUM_EN
  localparam bit CKS = 1'b1;
`else
  localparam bit CKS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [7:0]  req_opcode = '0;
  logic [7:0]  req_block = '0;
  logic [3:0]  req_reg = '0;
  logic [15:0] req_data = '0;
  logic [2:0]  req_len = '0;
  logic [7:0]  command_out;
  logic        command_out_ready;
  logic [5:0]  fifo_count = '0;
  logic        invalid_command = 1'b0;
  logic        busy;
  logic        error;
  logic [15:0] frames_sent;

  always #5 clk = ~clk;

  engine_cmd_tx #(
    .n_blocks(256),
    .n_block_registers(16),
    .data_width(DW),
    .spi_fifo_length(FL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_opcode(req_opcode),
    .req_block(req_block),
    .req_reg(req_reg),
    .req_data(req_data),
    .req_len(req_len),
    .command_out(command_out),
    .command_out_ready(command_out_ready),
    .fifo_count(fifo_count),
    .invalid_command(invalid_command),
    .busy(busy),
    .error(error),
    .frames_sent(frames_sent)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [7:0]  exp_q[$];
  logic        exp_err = 1'b0;
  logic [15:0] exp_frames = '0;

  // Stream monitor
  logic [7:0] cap[$];
  int         cap_cyc[$];
  int         cyc = 0;
  int         credit_viol = 0;
  int         hold_viol = 0;
  logic [5:0] prev_fc = '0;
  logic [7:0] prev_out = '0;
  logic       prev_rst = 1'b1;

  always @(negedge clk) begin
    cyc++;
    if (command_out_ready) begin
      cap.push_back(command_out);
      cap_cyc.push_back(cyc);
      if (prev_fc > 6'(FL - 2)) credit_viol++;
    end else if (!reset && !prev_rst && command_out !== prev_out) begin
      hold_viol++;
    end
    prev_fc  = fifo_count;
    prev_out = command_out;
    prev_rst = reset;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic model_frame(input logic [7:0] op, input logic [7:0] blk, input logic [3:0] rg,
                             input logic [15:0] d, input logic [2:0] len);
    logic [7:0] all[$];
    logic [7:0] x;
    int n;
    exp_q.delete();
    all.push_back(op);
    all.push_back(blk);
    all.push_back({4'h0, rg});
    for (int k = 0; k < DW / 8; k++) all.push_back(8'(d >> (DW - 8 - 8 * k)));
    n = (int'(len) > MAXLEN) ? MAXLEN : int'(len);
    x = '0;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(all[i]);
      x = x ^ all[i];
    end
    if (CKS && n > 0) exp_q.push_back(x);
    if (len == 3'd0 || int'(len) > MAXLEN) exp_err = 1'b1;
    if (n > 0) exp_frames = exp_frames + 16'd1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    exp_err = 1'b0;
    exp_frames = '0;
    cap.delete();
    cap_cyc.delete();
  endtask

  task automatic send_req(input logic [7:0] op, input logic [7:0] blk, input logic [3:0] rg,
                          input logic [15:0] d, input logic [2:0] len);
    @(posedge clk); #1;
    req_opcode = op; req_block = blk; req_reg = rg; req_data = d; req_len = len;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid  = 1'b0;
    req_opcode = 8'($urandom); req_block = 8'($urandom); req_reg = 4'($urandom);
    req_data   = 16'($urandom); req_len = 3'($urandom);
  endtask

  task automatic wait_done(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy) begin done = 1'b1; break; end
    end
    @(negedge clk);
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_timeout: busy=%0b required=0", name, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %0b want 1", req_ready); end
    checks++; if (command_out !== 8'h00) begin errors++; $display("FAIL reset_command_out: got %02h want 00", command_out); end
    checks++; if (command_out_ready !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %0b want 0", command_out_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error: got %0b want 0", error); end
    checks++; if (frames_sent !== 16'h0) begin errors++; $display("FAIL reset_frames: got %04h want 0000", frames_sent); end
    #1 reset = 1'b0;
    exp_err = 1'b0;
    exp_frames = '0;
  endtask

  task automatic test_basic();
    do_reset();
    fifo_count = '0;
    model_frame(8'h12, 8'h05, 4'h3, 16'hBEEF, 3'd5);
    send_req(8'h12, 8'h05, 4'h3, 16'hBEEF, 3'd5);
    wait_done("basic");
    checks++;
    if (cap.size() != exp_q.size()) begin errors++; $display("FAIL basic_count: got %0d bytes want %0d", cap.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
      checks++;
      if (cap[i] !== exp_q[i]) begin errors++; $display("FAIL basic_byte%0d: got %02h want %02h", i, cap[i], exp_q[i]); end
    end
    if (cap_cyc.size() == exp_q.size()) begin
      checks++;
      if (cap_cyc[cap_cyc.size()-1] - cap_cyc[0] != exp_q.size() - 1) begin
        errors++;
        $display("FAIL basic_consecutive: span %0d cycles want %0d", cap_cyc[cap_cyc.size()-1] - cap_cyc[0], exp_q.size() - 1);
      end
    end
    checks++; if (frames_sent !== exp_frames) begin errors++; $display("FAIL basic_frames: got %0d want %0d", frames_sent, exp_frames); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL basic_error: got %0b want 0", error); end
  endtask

  task automatic test_backpressure();
    do_reset();
    fifo_count = 6'd31;
    model_frame(8'h12, 8'h05, 4'h3, 16'hBEEF, 3'd5);
    send_req(8'h12, 8'h05, 4'h3, 16'hBEEF, 3'd5);
    repeat (10) @(negedge clk);
    checks++; if (cap.size() != 0) begin errors++; $display("FAIL bp_held: got %0d strobes want 0", cap.size()); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy: got %0b want 1", busy); end
    @(posedge clk); #1 fifo_count = 6'd30;
    wait_done("bp");
    checks++;
    if (cap.size() != exp_q.size()) begin errors++; $display("FAIL bp_count: got %0d bytes want %0d", cap.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
      checks++;
      if (cap[i] !== exp_q[i]) begin errors++; $display("FAIL bp_byte%0d: got %02h want %02h", i, cap[i], exp_q[i]); end
    end
    checks++; if (frames_sent !== exp_frames) begin errors++; $display("FAIL bp_frames: got %0d want %0d", frames_sent, exp_frames); end
    fifo_count = '0;
  endtask

  task automatic test_len_edges();
    do_reset();
    model_frame(8'hA1, 8'h22, 4'h7, 16'h1234, 3'd0);
    send_req(8'hA1, 8'h22, 4'h7, 16'h1234, 3'd0);
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL len0_ready: got %0b want 1", req_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL len0_busy: got %0b want 0", busy); end
    repeat (5) @(negedge clk);
    checks++; if (cap.size() != 0) begin errors++; $display("FAIL len0_strobes: got %0d want 0", cap.size()); end
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL len0_error: got %0b want 1", error); end
    checks++; if (frames_sent !== exp_frames) begin errors++; $display("FAIL len0_frames: got %0d want %0d", frames_sent, exp_frames); end

    do_reset();
    model_frame(8'h5C, 8'hF0, 4'hE, 16'hC3A5, 3'd7);
    send_req(8'h5C, 8'hF0, 4'hE, 16'hC3A5, 3'd7);
    wait_done("len7");
    checks++;
    if (cap.size() != exp_q.size()) begin errors++; $display("FAIL len7_count: got %0d bytes want %0d", cap.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
      checks++;
      if (cap[i] !== exp_q[i]) begin errors++; $display("FAIL len7_byte%0d: got %02h want %02h", i, cap[i], exp_q[i]); end
    end
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL len7_error: got %0b want 1", error); end
    checks++; if (frames_sent !== exp_frames) begin errors++; $display("FAIL len7_frames: got %0d want %0d", frames_sent, exp_frames); end
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    do_reset();
    fifo_count = '0;
    send_req(8'h77, 8'h01, 4'h2, 16'h3344, 3'd5);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #1;
      if (cap.size() >= 2) begin seen = 1'b1; break; end
    end
    checks++; if (!seen) begin errors++; $display("FAIL rstmid_two_bytes: got %0d want 2", cap.size()); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %0b want 0", busy); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %0b want 1", req_ready); end
    #1 reset = 1'b0;
    exp_err = 1'b0;
    exp_frames = '0;
    repeat (10) @(negedge clk);
    checks++; if (cap.size() != 2) begin errors++; $display("FAIL rstmid_no_more: got %0d strobes want 2", cap.size()); end
    cap.delete();
    cap_cyc.delete();
    model_frame(8'h9E, 8'h44, 4'h9, 16'h0F1E, 3'd5);
    send_req(8'h9E, 8'h44, 4'h9, 16'h0F1E, 3'd5);
    wait_done("rstmid_new");
    checks++;
    if (cap.size() != exp_q.size()) begin errors++; $display("FAIL rstmid_new_count: got %0d want %0d", cap.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
      checks++;
      if (cap[i] !== exp_q[i]) begin errors++; $display("FAIL rstmid_new_byte%0d: got %02h want %02h", i, cap[i], exp_q[i]); end
    end
    checks++; if (frames_sent !== exp_frames) begin errors++; $display("FAIL rstmid_frames: got %0d want %0d", frames_sent, exp_frames); end
  endtask

  task automatic test_invalid();
    do_reset();
    fifo_count = '0;
    model_frame(8'h3D, 8'hAB, 4'h5, 16'h6789, 3'd5);
    send_req(8'h3D, 8'hAB, 4'h5, 16'h6789, 3'd5);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #1;
      if (cap.size() >= 2) break;
    end
    invalid_command = 1'b1;
    @(negedge clk); #1;
    invalid_command = 1'b0;
    exp_err = 1'b1;
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL inv_error_set: got %0b want 1", error); end
    wait_done("inv");
    checks++;
    if (cap.size() != exp_q.size()) begin errors++; $display("FAIL inv_count: got %0d want %0d", cap.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
      checks++;
      if (cap[i] !== exp_q[i]) begin errors++; $display("FAIL inv_byte%0d: got %02h want %02h", i, cap[i], exp_q[i]); end
    end
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL inv_error_sticky: got %0b want 1", error); end
    checks++; if (frames_sent !== exp_frames) begin errors++; $display("FAIL inv_frames: got %0d want %0d", frames_sent, exp_frames); end
  endtask

  task automatic test_random();
    logic [7:0]  op, blk;
    logic [3:0]  rg;
    logic [15:0] d;
    logic [2:0]  len;
    bit done;
    do_reset();
    for (int t = 0; t < 40; t++) begin
      op = 8'($urandom); blk = 8'($urandom); rg = 4'($urandom); d = 16'($urandom);
      len = 3'($urandom_range(0, 7));
      fifo_count = 6'($urandom_range(26, 32));
      cap.delete();
      cap_cyc.delete();
      model_frame(op, blk, rg, d, len);
      send_req(op, blk, rg, d, len);
      done = 1'b0;
      for (int i = 0; i < 400; i++) begin
        @(negedge clk);
        if (!busy) begin done = 1'b1; break; end
        @(posedge clk); #1 fifo_count = 6'($urandom_range(26, 32));
      end
      @(negedge clk);
      checks++; if (!done) begin errors++; $display("FAIL rnd%0d_timeout: busy=%0b want 0", t, busy); end
      checks++;
      if (cap.size() != exp_q.size()) begin errors++; $display("FAIL rnd%0d_count: got %0d want %0d (len %0d)", t, cap.size(), exp_q.size(), len); end
      for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
        checks++;
        if (cap[i] !== exp_q[i]) begin errors++; $display("FAIL rnd%0d_byte%0d: got %02h want %02h", t, i, cap[i], exp_q[i]); end
      end
      checks++; if (error !== exp_err) begin errors++; $display("FAIL rnd%0d_error: got %0b want %0b", t, error, exp_err); end
      checks++; if (frames_sent !== exp_frames) begin errors++; $display("FAIL rnd%0d_frames: got %0d want %0d", t, frames_sent, exp_frames); end
    end
    fifo_count = '0;
  endtask

  task automatic test_wrap();
    do_reset();
    fifo_count = '0;
    @(negedge clk);
    force dut.cnt_q = 16'hFFFF;
    @(posedge clk); #1;
    release dut.cnt_q;
    @(negedge clk);
    exp_frames = 16'hFFFF;
    checks++; if (frames_sent !== exp_frames) begin errors++; $display("FAIL wrap_preload: got %04h want %04h", frames_sent, exp_frames); end
    model_frame(8'h01, 8'h02, 4'h3, 16'h0405, 3'd1);
    send_req(8'h01, 8'h02, 4'h3, 16'h0405, 3'd1);
    wait_done("wrap");
    checks++; if (frames_sent !== exp_frames) begin errors++; $display("FAIL wrap_frames: got %04h want %04h", frames_sent, exp_frames); end
  endtask

  task automatic test_stream_rules();
    checks++; if (credit_viol != 0) begin errors++; $display("FAIL credit_rule: got %0d violations want 0", credit_viol); end
    checks++; if (hold_viol != 0) begin errors++; $display("FAIL out_hold: got %0d changes without strobe want 0", hold_viol); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_len_edges();
    test_reset_mid();
    test_invalid();
    test_random();
    test_wrap();
    test_stream_rules();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
